dvga_pixel_source: RTL and testbench

- Head of the dvga display pipeline, upstream of the sprite stages.
- Generates VGA raster timing (hsync, vsync, blank) from parameterised counters.
- Pulls RGB565 pixels from a first-word-fall-through line FIFO during the visible area and expands them to 8-bit r/g/b.
- Drives the r/g/b/hsync/vsync/blank stream that the sprite pre/post stages consume, and flags FIFO underruns.

---
 rtl/dvga_pixel_source_pkg.sv | 41 ++++
 rtl/dvga_pixel_source_if.sv | 9 +
 rtl/dvga_timing_counter.sv | 73 +++++++
 rtl/dvga_pixel_source.sv | 102 ++++++++++
 tb/tb_dvga_pixel_source.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/dvga_pixel_source_pkg.sv
// rtl/dvga_pixel_source_pkg.sv - shared dvga timing defaults, RGB565 layout and expansion helper
package dvga_pixel_source_pkg;

    localparam int DVGA_H_VIS  = 640;
    localparam int DVGA_H_FP   = 16;
    localparam int DVGA_H_SYNC = 96;
    localparam int DVGA_H_BP   = 48;
    localparam int DVGA_V_VIS  = 480;
    localparam int DVGA_V_FP   = 10;
    localparam int DVGA_V_SYNC = 2;
    localparam int DVGA_V_BP   = 33;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the top bits into the new LSBs maps full scale to 0xFF exactly.
    function automatic rgb888_t rgb565_expand(input logic [15:0] w);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        rgb888_t    px;
        r5   = w[RGB565_R_MSB:RGB565_R_LSB];
        g6   = w[RGB565_G_MSB:RGB565_G_LSB];
        b5   = w[RGB565_B_MSB:RGB565_B_LSB];
        px.r = {r5, r5[4:2]};
        px.g = {g6, g6[5:4]};
        px.b = {b5, b5[4:2]};
        return px;
    endfunction

endpackage

// File: rtl/dvga_pixel_source_if.sv
// rtl/dvga_pixel_source_if.sv - first-word-fall-through line FIFO read port
interface dvga_pixel_source_if;
    logic [15:0] pix_dat;
    logic        pix_empty;
    logic        pix_rd;

    modport master (output pix_dat, output pix_empty, input  pix_rd);
    modport slave  (input  pix_dat, input  pix_empty, output pix_rd);
endinterface

// File: rtl/dvga_timing_counter.sv
// rtl/dvga_timing_counter.sv - h/v raster counters with visible and sync decode
module dvga_timing_counter #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic visible_o,
    output logic hsync_act_o,
    output logic vsync_act_o,
    output logic origin_o
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    // One extra bit so sync end bounds equal to the total still fit.
    localparam logic [HW:0] H_VIS_E = (HW+1)'(H_VIS);
    localparam logic [HW:0] H_SS_E  = (HW+1)'(H_VIS + H_FP);
    localparam logic [HW:0] H_SE_E  = (HW+1)'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW:0] V_VIS_E = (VW+1)'(V_VIS);
    localparam logic [VW:0] V_SS_E  = (VW+1)'(V_VIS + V_FP);
    localparam logic [VW:0] V_SE_E  = (VW+1)'(V_VIS + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_ext       = {1'b0, h_q};
    assign v_ext       = {1'b0, v_q};
    assign visible_o   = (h_ext < H_VIS_E) && (v_ext < V_VIS_E);
    assign hsync_act_o = (h_ext >= H_SS_E) && (h_ext < H_SE_E);
    assign vsync_act_o = (v_ext >= V_SS_E) && (v_ext < V_SE_E);
    assign origin_o    = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/dvga_pixel_source.sv
// rtl/dvga_pixel_source.sv - raster timing plus FIFO-fed RGB565 to RGB888 pixel stream
module dvga_pixel_source
    import dvga_pixel_source_pkg::*;
#(
    parameter int H_VIS     = DVGA_H_VIS,
    parameter int H_FP      = DVGA_H_FP,
    parameter int H_SYNC    = DVGA_H_SYNC,
    parameter int H_BP      = DVGA_H_BP,
    parameter int V_VIS     = DVGA_V_VIS,
    parameter int V_FP      = DVGA_V_FP,
    parameter int V_SYNC    = DVGA_V_SYNC,
    parameter int V_BP      = DVGA_V_BP,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    dvga_pixel_source_if.slave        fifo,
    input  logic                      clr_underrun_i,
    output logic                      underrun_o,
    output logic                      frame_start_o,
    output logic [7:0]                r_o,
    output logic [7:0]                g_o,
    output logic [7:0]                b_o,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      blank_o
);

    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    logic    visible, hsync_act, vsync_act, origin;
    logic    active, pop, starve;
    rgb888_t pix;
    rgb888_t rgb_q, rgb_d;
    logic    blank_q, blank_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    fs_q, fs_d;
    logic    underrun_q, underrun_d;

    dvga_timing_counter #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .visible_o   (visible),
        .hsync_act_o (hsync_act),
        .vsync_act_o (vsync_act),
        .origin_o    (origin)
    );

    assign active = en_i & visible;
    assign pop    = active & ~fifo.pix_empty;
    assign starve = active & fifo.pix_empty;
    assign pix    = rgb565_expand(fifo.pix_dat);

    // Gate with reset so the FIFO never loses a word while we are held in reset.
    assign fifo.pix_rd = rst & pop;

    always_comb begin
        rgb_d      = '0;
        if (pop) rgb_d = pix;
        blank_d    = ~active;
        hsync_d    = (en_i & hsync_act) ? HS_ON : ~HS_ON;
        vsync_d    = (en_i & vsync_act) ? VS_ON : ~VS_ON;
        fs_d       = en_i & origin;
        underrun_d = starve | (underrun_q & ~clr_underrun_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q      <= '0;
            blank_q    <= 1'b1;
            hsync_q    <= ~HS_ON;
            vsync_q    <= ~VS_ON;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            blank_q    <= blank_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

    assign r_o           = rgb_q.r;
    assign g_o           = rgb_q.g;
    assign b_o           = rgb_q.b;
    assign blank_o       = blank_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_dvga_pixel_source.sv
// tb/tb_dvga_pixel_source.sv - directed self-checking bench for dvga_pixel_source
module tb_dvga_pixel_source;

    logic       clk;
    logic       rst;
    logic       en_i;
    logic       clr_underrun_i;
    logic       underrun_o;
    logic       frame_start_o;
    logic [7:0] r_o, g_o, b_o;
    logic       hsync_o, vsync_o, blank_o;

    dvga_pixel_source_if fifo_if ();

    dvga_pixel_source #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .fifo           (fifo_if.slave),
        .clr_underrun_i (clr_underrun_i),
        .underrun_o     (underrun_o),
        .frame_start_o  (frame_start_o),
        .r_o            (r_o),
        .g_o            (g_o),
        .b_o            (b_o),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .blank_o        (blank_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total, bad;
    int          cur_h, cur_v, out_h, out_v;
    logic        out_en, rd_prev;
    int          pops, fifo_idx, popped;
    bit          fifo_auto;
    logic [15:0] words   [4];
    logic [23:0] exp_pix [4];

    // Advance one pixel clock, tracking which raster position the outputs now show.
    task automatic tick();
        @(negedge clk);
        rd_prev = fifo_if.pix_rd;
        out_h   = cur_h;
        out_v   = cur_v;
        out_en  = en_i;
        @(posedge clk);
        #1;
        if (out_en) begin
            if (cur_h == 7) begin
                cur_h = 0;
                cur_v = (cur_v == 5) ? 0 : cur_v + 1;
            end else begin
                cur_h = cur_h + 1;
            end
        end else begin
            cur_h = 0;
            cur_v = 0;
        end
        if (rd_prev) pops++;
        if (rd_prev && fifo_auto) begin
            popped   = fifo_idx;
            fifo_idx = (fifo_idx + 1) % 4;
            fifo_if.pix_dat = words[fifo_idx];
        end
    endtask

    task automatic run_to(input int h, input int v, output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (cur_h == h && cur_v == v) ok = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en_i = 1'b1; clr_underrun_i = 1'b0;
        fifo_if.pix_dat = 16'hFFFF; fifo_if.pix_empty = 1'b0;
        @(posedge clk); #1;
        total++; if (blank_o !== 1'b1) begin bad++; $display("FAIL rst_blank got=%b exp=1", blank_o); end
        total++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin bad++; $display("FAIL rst_sync got=%b%b exp=11", hsync_o, vsync_o); end
        total++; if ({r_o, g_o, b_o} !== 24'h0) begin bad++; $display("FAIL rst_rgb got=%h exp=000000", {r_o, g_o, b_o}); end
        total++; if (underrun_o !== 1'b0 || frame_start_o !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", underrun_o, frame_start_o); end
        total++; if (fifo_if.pix_rd !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0", fifo_if.pix_rd); end
        #2 rst = 1'b1;
        cur_h = 0; cur_v = 0;
    endtask

    task automatic test_timing();
        int blanks, fs_cnt;
        logic e_hs, e_vs, e_bl, e_fs;
        blanks = 0; fs_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            tick();
            e_hs = (out_h == 5 || out_h == 6) ? 1'b0 : 1'b1;
            e_vs = (out_v == 4) ? 1'b0 : 1'b1;
            e_bl = (out_h < 4 && out_v < 3) ? 1'b0 : 1'b1;
            e_fs = (i % 48 == 0) ? 1'b1 : 1'b0;
            total++; if (hsync_o !== e_hs) begin bad++; $display("FAIL hsync h=%0d v=%0d got=%b exp=%b", out_h, out_v, hsync_o, e_hs); end
            total++; if (vsync_o !== e_vs) begin bad++; $display("FAIL vsync h=%0d v=%0d got=%b exp=%b", out_h, out_v, vsync_o, e_vs); end
            total++; if (blank_o !== e_bl) begin bad++; $display("FAIL blank h=%0d v=%0d got=%b exp=%b", out_h, out_v, blank_o, e_bl); end
            total++; if (frame_start_o !== e_fs) begin bad++; $display("FAIL frame_start cyc=%0d got=%b exp=%b", i, frame_start_o, e_fs); end
            if (blank_o === 1'b0) blanks++;
            if (frame_start_o === 1'b1) fs_cnt++;
            if (i % 48 == 47) begin
                total++; if (blanks != 12) begin bad++; $display("FAIL visible_count got=%0d exp=12", blanks); end
                blanks = 0;
            end
        end
        total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    endtask

    task automatic test_pixels();
        logic [23:0] e_px;
        fifo_auto = 1; fifo_idx = 0; pops = 0;
        fifo_if.pix_dat = words[0];
        for (int i = 0; i < 48; i++) begin
            tick();
            e_px = rd_prev ? exp_pix[popped] : 24'h0;
            total++; if ({r_o, g_o, b_o} !== e_px) begin bad++; $display("FAIL pixel h=%0d v=%0d got=%h exp=%h", out_h, out_v, {r_o, g_o, b_o}, e_px); end
        end
        total++; if (pops != 12) begin bad++; $display("FAIL pops_per_frame got=%0d exp=12", pops); end
        fifo_auto = 0;
        fifo_if.pix_dat = 16'hFFFF;
    endtask

    task automatic test_underrun();
        bit ok;
        run_to(2, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL underrun_seek got=timeout exp=h2v1"); end
        fifo_if.pix_empty = 1'b1;
        tick();
        fifo_if.pix_empty = 1'b0;
        total++; if (rd_prev !== 1'b0) begin bad++; $display("FAIL underrun_pop got=%b exp=0", rd_prev); end
        total++; if ({r_o, g_o, b_o} !== 24'h0) begin bad++; $display("FAIL underrun_rgb got=%h exp=000000", {r_o, g_o, b_o}); end
        total++; if (blank_o !== 1'b0) begin bad++; $display("FAIL underrun_blank got=%b exp=0", blank_o); end
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b exp=1", underrun_o); end
        repeat (3) tick();
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", underrun_o); end
        clr_underrun_i = 1'b1;
        tick();
        clr_underrun_i = 1'b0;
        total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b exp=0", underrun_o); end
        run_to(0, 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL underrun_seek2 got=timeout exp=h0v2"); end
        fifo_if.pix_empty = 1'b1; clr_underrun_i = 1'b1;
        tick();
        fifo_if.pix_empty = 1'b0; clr_underrun_i = 1'b0;
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL underrun_set_wins got=%b exp=1", underrun_o); end
        clr_underrun_i = 1'b1;
        tick();
        clr_underrun_i = 1'b0;
    endtask

    task automatic test_enable();
        bit ok;
        run_to(3, 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL enable_seek got=timeout exp=h3v2"); end
        en_i = 1'b0;
        tick();
        total++; if (rd_prev !== 1'b0) begin bad++; $display("FAIL disabled_pop got=%b exp=0", rd_prev); end
        total++; if (blank_o !== 1'b1) begin bad++; $display("FAIL disabled_blank got=%b exp=1", blank_o); end
        total++; if ({hsync_o, vsync_o, frame_start_o} !== 3'b110) begin bad++; $display("FAIL disabled_sync got=%b exp=110", {hsync_o, vsync_o, frame_start_o}); end
        total++; if ({r_o, g_o, b_o} !== 24'h0) begin bad++; $display("FAIL disabled_rgb got=%h exp=000000", {r_o, g_o, b_o}); end
        tick();
        fifo_if.pix_dat = 16'h8410;
        en_i = 1'b1;
        tick();
        total++; if (rd_prev !== 1'b1) begin bad++; $display("FAIL reenable_pop got=%b exp=1", rd_prev); end
        total++; if (frame_start_o !== 1'b1 || blank_o !== 1'b0) begin bad++; $display("FAIL reenable_fs got=%b%b exp=10", frame_start_o, blank_o); end
        total++; if ({r_o, g_o, b_o} !== 24'h848284) begin bad++; $display("FAIL reenable_rgb got=%h exp=848284", {r_o, g_o, b_o}); end
        fifo_if.pix_dat = 16'hFFFF;
    endtask

    task automatic test_async_reset();
        fifo_if.pix_empty = 1'b1;
        tick();
        fifo_if.pix_empty = 1'b0;
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL pre_reset_underrun got=%b exp=1", underrun_o); end
        #2 rst = 1'b0;
        #1;
        total++; if (blank_o !== 1'b1 || hsync_o !== 1'b1 || vsync_o !== 1'b1) begin bad++; $display("FAIL async_rst_timing got=%b%b%b exp=111", blank_o, hsync_o, vsync_o); end
        total++; if ({r_o, g_o, b_o} !== 24'h0) begin bad++; $display("FAIL async_rst_rgb got=%h exp=000000", {r_o, g_o, b_o}); end
        total++; if (underrun_o !== 1'b0 || frame_start_o !== 1'b0) begin bad++; $display("FAIL async_rst_flags got=%b%b exp=00", underrun_o, frame_start_o); end
        total++; if (fifo_if.pix_rd !== 1'b0) begin bad++; $display("FAIL async_rst_pop got=%b exp=0", fifo_if.pix_rd); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        cur_h = 0; cur_v = 0;
        tick();
        total++; if (frame_start_o !== 1'b1 || blank_o !== 1'b0) begin bad++; $display("FAIL post_rst_fs got=%b%b exp=10", frame_start_o, blank_o); end
        total++; if ({r_o, g_o, b_o} !== 24'hFFFFFF) begin bad++; $display("FAIL post_rst_rgb got=%h exp=ffffff", {r_o, g_o, b_o}); end
    endtask

    initial begin
        total = 0; bad = 0; pops = 0; fifo_idx = 0; popped = 0; fifo_auto = 0;
        cur_h = 0; cur_v = 0; out_h = 0; out_v = 0; out_en = 1'b0; rd_prev = 1'b0;
        words[0]   = 16'hF800;   words[1]   = 16'h07E0;
        words[2]   = 16'h001F;   words[3]   = 16'hFFFF;
        exp_pix[0] = 24'hFF0000; exp_pix[1] = 24'h00FF00;
        exp_pix[2] = 24'h0000FF; exp_pix[3] = 24'hFFFFFF;
        test_reset();
        test_timing();
        test_pixels();
        test_underrun();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
